// File: rtl/morse_stream_decoder_if.sv
// Character output channel of the Morse stream decoder: valid/ready character
// transfer plus the word-gap and error side-band pulses.
interface morse_stream_decoder_if #(
  parameter int MAX_ELEMS = 6
);
  localparam int LW = $clog2(MAX_ELEMS + 1);

  logic [MAX_ELEMS-1:0] char_data;
  logic [LW-1:0]        char_len;
  logic                 char_valid;
  logic                 char_ready;
  logic                 word_gap;
  logic                 err;
  logic [1:0]           err_code;

  modport master (
    output char_data, char_len, char_valid, word_gap, err, err_code,
    input  char_ready
  );

  modport slave (
    input  char_data, char_len, char_valid, word_gap, err, err_code,
    output char_ready
  );
endinterface

// File: rtl/morse_stream_decoder.sv
// Morse stream decoder: times button presses and gaps against an internal unit
// base, assembles dot/dash characters and hands them out through a holding register.
module morse_stream_decoder #(
  parameter int TICKS_PER_UNIT = 5_000_000,
  parameter int MAX_ELEMS      = 6,
  parameter int DASH_UNITS     = 2,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 7,
  parameter int STUCK_UNITS    = 20
) (
  input  logic                   clk_100MHz,
  input  logic                   reset,
  input  logic                   user_btn,
  morse_stream_decoder_if.master out_if
);

  // State | meaning
  // IDLE     | between words, no partial character
  // PRESS    | button held, timing the current element
  // GAP      | button released, waiting for next element or char/word gap
  // ERR_WAIT | stuck press reported, waiting for the release
  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_GAP,
    S_ERR_WAIT
  } state_t;

  localparam int UMAX = (WORD_GAP_UNITS > STUCK_UNITS) ? WORD_GAP_UNITS : STUCK_UNITS;
  localparam int UW   = $clog2(UMAX + 1);
  localparam int TW   = $clog2(TICKS_PER_UNIT);
  localparam int LW   = $clog2(MAX_ELEMS + 1);

  localparam logic [1:0] ERR_OVERFLOW = 2'b01;
  localparam logic [1:0] ERR_STUCK    = 2'b10;
  localparam logic [1:0] ERR_OVERRUN  = 2'b11;

  state_t               state_q;
  logic                 btn_q;
  logic [TW-1:0]        tick_q, tick_d;
  logic [UW-1:0]        units_q, units_d;
  logic [MAX_ELEMS-1:0] elems_q;
  logic [LW-1:0]        count_q;
  logic [MAX_ELEMS-1:0] data_q;
  logic [LW-1:0]        len_q;
  logic                 valid_q;
  logic                 word_gap_q;
  logic                 err_q;
  logic [1:0]           err_code_q;

  logic rise, fall, unit_tc;
  logic char_hit, word_hit, stuck_hit, is_dash, accept;

  // tick_q/units_q together hold D, the samples seen at the current level;
  // the *_hit strobes fire in the cycle whose sample brings D onto a threshold.
  always_comb begin
    rise    = user_btn & ~btn_q;
    fall    = ~user_btn & btn_q;
    unit_tc = 1'b0;
    tick_d  = tick_q + TW'(1);
    units_d = units_q;
    if (rise | fall) begin
      tick_d  = TW'(1);
      units_d = '0;
    end else if (tick_q == TW'(TICKS_PER_UNIT - 1)) begin
      tick_d  = '0;
      unit_tc = 1'b1;
      if (units_q != UW'(UMAX)) units_d = units_q + UW'(1);
    end
    char_hit  = unit_tc && (units_q == UW'(CHAR_GAP_UNITS - 1));
    word_hit  = unit_tc && (units_q == UW'(WORD_GAP_UNITS - 1));
    stuck_hit = unit_tc && (units_q == UW'(STUCK_UNITS - 1));
    is_dash   = (units_q >= UW'(DASH_UNITS));
    accept    = valid_q & out_if.char_ready;
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      btn_q      <= 1'b0;
      tick_q     <= '0;
      units_q    <= '0;
      elems_q    <= '0;
      count_q    <= '0;
      data_q     <= '0;
      len_q      <= '0;
      valid_q    <= 1'b0;
      word_gap_q <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      btn_q      <= user_btn;
      tick_q     <= tick_d;
      units_q    <= units_d;
      word_gap_q <= 1'b0;
      err_q      <= 1'b0;
      if (accept) valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          elems_q <= '0;
          count_q <= '0;
          if (rise) state_q <= S_PRESS;
        end

        S_PRESS: begin
          if (fall) begin
            if (count_q == LW'(MAX_ELEMS)) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_OVERFLOW;
              elems_q    <= '0;
              count_q    <= '0;
              state_q    <= S_IDLE;
            end else begin
              for (int i = 0; i < MAX_ELEMS; i++)
                if (count_q == LW'(i)) elems_q[i] <= is_dash;
              count_q <= count_q + LW'(1);
              state_q <= S_GAP;
            end
          end else if (stuck_hit) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_STUCK;
            elems_q    <= '0;
            count_q    <= '0;
            state_q    <= S_ERR_WAIT;
          end
        end

        S_GAP: begin
          if (rise) begin
            state_q <= S_PRESS;
          end else if (word_hit) begin
            word_gap_q <= 1'b1;
            state_q    <= S_IDLE;
          end else if (char_hit) begin
            // A character may reload the register in the same cycle it is taken.
            if (!valid_q || accept) begin
              data_q  <= elems_q;
              len_q   <= count_q;
              valid_q <= 1'b1;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_OVERRUN;
            end
            elems_q <= '0;
            count_q <= '0;
          end
        end

        S_ERR_WAIT: begin
          if (fall) state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_if.char_data  = data_q;
  assign out_if.char_len   = len_q;
  assign out_if.char_valid = valid_q;
  assign out_if.word_gap   = word_gap_q;
  assign out_if.err        = err_q;
  assign out_if.err_code   = err_code_q;

endmodule
